// File: rtl/sparse_qc_pkg.sv
// sparse_qc_pkg: shared types and helpers for the sparse quasi-cyclic multiplier.
//   entry_t    : one table slot {valid, col, shift}
//   fill_st_e  : input-side FSM states
//   read_st_e  : output-side FSM states
//   idx_w()    : index width for a count (at least 1 bit)
//   rotl()     : rotate-left within the low z bits of a ROT_W container
package sparse_qc_pkg;

    // Containers sized for any sensible parameterisation; unused upper bits
    // are constant zero and fold away.
    localparam int unsigned ROT_W       = 1024;
    localparam int unsigned ENT_COL_W   = 16;
    localparam int unsigned ENT_SHIFT_W = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [ENT_COL_W-1:0]   col;
        logic [ENT_SHIFT_W-1:0] shift;
    } entry_t;

    typedef enum logic {ST_FILL, ST_WAIT} fill_st_e;
    typedef enum logic {ST_IDLE, ST_READ} read_st_e;

    // Rotate left by s within a z-bit word (s < z). For s == 0 the right
    // shift by z yields zero, so the identity case needs no special handling.
    function automatic logic [ROT_W-1:0] rotl(input logic [ROT_W-1:0]       d,
                                              input logic [ENT_SHIFT_W-1:0] s,
                                              input int unsigned            z);
        logic [ROT_W-1:0] mask;
        logic [ROT_W-1:0] dm;
        mask = {ROT_W{1'b1}} >> (ROT_W - z);
        dm   = d & mask;
        return ((dm << s) | (dm >> (z - 32'(s)))) & mask;
    endfunction

endpackage

// File: rtl/sparse_qc_entry_table.sv
// sparse_qc_entry_table: runtime-loaded circulant entry table.
//   clk, rst          : clock, synchronous active-high reset
//   cfg_take          : a config write is accepted this cycle
//   cfg_row/slot/col/shift/enable : write target and payload
//   cur_col, data     : current input column and block
//   cfg_error         : one-cycle pulse after a rejected write
//   row_xor           : per-row XOR of rotl(data, shift) over matching slots
module sparse_qc_entry_table
    import sparse_qc_pkg::*;
#(
    parameter int Z     = 96,
    parameter int N_IN  = 144,
    parameter int N_OUT = 4,
    parameter int MAX_W = 4,
    localparam int RW   = idx_w(N_OUT),
    localparam int SW   = idx_w(MAX_W),
    localparam int CW   = idx_w(N_IN),
    localparam int HW   = idx_w(Z)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_take,
    input  logic [RW-1:0]             cfg_row,
    input  logic [SW-1:0]             cfg_slot,
    input  logic [CW-1:0]             cfg_col,
    input  logic [HW-1:0]             cfg_shift,
    input  logic                      cfg_enable,
    input  logic [CW-1:0]             cur_col,
    input  logic [Z-1:0]              data,
    output logic                      cfg_error,
    output logic [N_OUT-1:0][Z-1:0]   row_xor
);

    entry_t [N_OUT-1:0][MAX_W-1:0] tbl_q, tbl_d;
    logic                          cfg_error_q, cfg_error_d;
    logic                          cfg_bad;
    logic [ROT_W-1:0]              dx;
    logic [ROT_W-1:0]              rx;

    always_comb begin
        cfg_bad     = (32'(cfg_shift) >= 32'(Z)) || (32'(cfg_col) >= 32'(N_IN));
        cfg_error_d = cfg_take && cfg_bad;
        tbl_d       = tbl_q;
        if (cfg_take && !cfg_bad) begin
            for (int r = 0; r < N_OUT; r++) begin
                for (int w = 0; w < MAX_W; w++) begin
                    if (cfg_row == RW'(r) && cfg_slot == SW'(w)) begin
                        tbl_d[r][w] = '{valid: cfg_enable,
                                        col:   ENT_COL_W'(cfg_col),
                                        shift: ENT_SHIFT_W'(cfg_shift)};
                    end
                end
            end
        end
    end

    // Every matching slot contributes; identical entries cancel by XOR.
    always_comb begin
        dx         = '0;
        dx[Z-1:0]  = data;
        rx         = '0;
        for (int r = 0; r < N_OUT; r++) begin
            row_xor[r] = '0;
            for (int w = 0; w < MAX_W; w++) begin
                if (tbl_q[r][w].valid && tbl_q[r][w].col == ENT_COL_W'(cur_col)) begin
                    rx         = rotl(dx, tbl_q[r][w].shift, Z);
                    row_xor[r] = row_xor[r] ^ rx[Z-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q       <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign cfg_error = cfg_error_q;

endmodule

// File: rtl/sparse_qc_mult.sv
// sparse_qc_mult: streaming Z-bit block x sparse quasi-cyclic matrix multiply.
// N_IN input blocks per frame produce N_OUT output blocks; two accumulator
// banks let frame k+1 fill while frame k is read out.
//   i_clock, i_reset                       : clock, sync active-high reset
//   i_input_data/valid, o_input_ready      : input block stream (col = beat)
//   o_output_data/valid/last, i_output_ready : output row stream
//   i_cfg_valid/row/slot/col/shift/enable  : table write request
//   o_cfg_ready, o_cfg_error               : write accept / reject pulse
module sparse_qc_mult
    import sparse_qc_pkg::*;
#(
    parameter int Z     = 96,
    parameter int N_IN  = 144,
    parameter int N_OUT = 4,
    parameter int MAX_W = 4,
    localparam int RW   = idx_w(N_OUT),
    localparam int SW   = idx_w(MAX_W),
    localparam int CW   = idx_w(N_IN),
    localparam int HW   = idx_w(Z)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic [Z-1:0]  i_input_data,
    input  logic          i_input_valid,
    output logic          o_input_ready,
    output logic [Z-1:0]  o_output_data,
    output logic          o_output_valid,
    output logic          o_output_last,
    input  logic          i_output_ready,
    input  logic          i_cfg_valid,
    input  logic [RW-1:0] i_cfg_row,
    input  logic [SW-1:0] i_cfg_slot,
    input  logic [CW-1:0] i_cfg_col,
    input  logic [HW-1:0] i_cfg_shift,
    input  logic          i_cfg_enable,
    output logic          o_cfg_ready,
    output logic          o_cfg_error
);

    fill_st_e                      fill_st_q, fill_st_d;
    read_st_e                      rd_st_q, rd_st_d;
    logic [CW-1:0]                 col_q, col_d;
    logic                          fill_bank_q, fill_bank_d;
    logic                          rd_bank_q, rd_bank_d;
    logic [1:0]                    full_q, full_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [1:0][N_OUT-1:0][Z-1:0]  acc_q, acc_d;
    logic [N_OUT-1:0][Z-1:0]       row_xor;

    logic cfg_ready, cfg_take, in_ready, in_take, wrap;
    logic out_valid, out_take, last_row, free_bank;

    sparse_qc_entry_table #(.Z(Z), .N_IN(N_IN), .N_OUT(N_OUT), .MAX_W(MAX_W)) u_tbl (
        .clk        (i_clock),
        .rst        (i_reset),
        .cfg_take   (cfg_take),
        .cfg_row    (i_cfg_row),
        .cfg_slot   (i_cfg_slot),
        .cfg_col    (i_cfg_col),
        .cfg_shift  (i_cfg_shift),
        .cfg_enable (i_cfg_enable),
        .cur_col    (col_q),
        .data       (i_input_data),
        .cfg_error  (o_cfg_error),
        .row_xor    (row_xor)
    );

    always_comb begin
        // Config only lands between frames so a frame never sees a mixed table.
        cfg_ready = !i_reset && (col_q == '0);
        cfg_take  = i_cfg_valid && cfg_ready;
        in_ready  = !i_reset && (fill_st_q == ST_FILL) && !cfg_take;
        in_take   = i_input_valid && in_ready;
        wrap      = in_take && (col_q == CW'(N_IN - 1));
        out_valid = !i_reset && (rd_st_q == ST_READ);
        out_take  = out_valid && i_output_ready;
        last_row  = (row_q == RW'(N_OUT - 1));
        free_bank = out_take && last_row;

        col_d = col_q;
        if (in_take) col_d = wrap ? '0 : col_q + CW'(1);

        acc_d = acc_q;
        if (in_take) begin
            for (int r = 0; r < N_OUT; r++) begin
                acc_d[fill_bank_q][r] = ((col_q == '0) ? '0 : acc_q[fill_bank_q][r]) ^ row_xor[r];
            end
        end

        full_d = full_q;
        if (wrap)      full_d[fill_bank_q] = 1'b1;
        if (free_bank) full_d[rd_bank_q]   = 1'b0;
        fill_bank_d = fill_bank_q ^ wrap;
        rd_bank_d   = rd_bank_q ^ free_bank;

        // A bank freed in the same cycle as the wrap does not cause a stall.
        fill_st_d = fill_st_q;
        case (fill_st_q)
            ST_FILL: if (wrap && full_q[~fill_bank_q] &&
                         !(free_bank && rd_bank_q == ~fill_bank_q)) fill_st_d = ST_WAIT;
            ST_WAIT: if (free_bank && rd_bank_q == fill_bank_q) fill_st_d = ST_FILL;
            default: fill_st_d = ST_FILL;
        endcase

        // Looking at full_d gives one-cycle latency from the last input beat.
        rd_st_d = rd_st_q;
        row_d   = row_q;
        case (rd_st_q)
            ST_IDLE: if (full_d[rd_bank_q]) rd_st_d = ST_READ;
            ST_READ: begin
                if (out_take) begin
                    if (last_row) begin
                        row_d   = '0;
                        rd_st_d = full_d[~rd_bank_q] ? ST_READ : ST_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: rd_st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fill_st_q   <= ST_FILL;
            rd_st_q     <= ST_IDLE;
            col_q       <= '0;
            fill_bank_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            row_q       <= '0;
            acc_q       <= '0;
        end else begin
            fill_st_q   <= fill_st_d;
            rd_st_q     <= rd_st_d;
            col_q       <= col_d;
            fill_bank_q <= fill_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
        end
    end

    assign o_input_ready  = in_ready;
    assign o_output_valid = out_valid;
    assign o_output_data  = out_valid ? acc_q[rd_bank_q][row_q] : '0;
    assign o_output_last  = out_valid && last_row;
    assign o_cfg_ready    = cfg_ready;

endmodule

// File: doc/sparse_qc_mult.md
Name: sparse_qc_mult

Overview:
Parametrised streaming multiplier of a Z-bit block vector by a sparse quasi-cyclic (circulant) binary matrix, for the LDPC encoder parity path. Each frame is N_IN input blocks; the block emits N_OUT output blocks, each the XOR of left-rotated input blocks selected by a runtime-loaded entry table. Ping-pong accumulator banks overlap the fill of frame k+1 with the readout of frame k.

Parameters:
Z, 96, circulant size; width of every data block
N_IN, 144, input blocks per frame (>=2)
N_OUT, 4, output blocks per frame (>=2, <=N_IN)
MAX_W, 4, table slots per output row (>=2)

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_input_data  in  Z  input block, column index = beat count in frame
i_input_valid  in  1  input valid
o_input_ready  out  1  input ready
o_output_data  out  Z  output block, row 0..N_OUT-1 in order
o_output_valid  out  1  output valid
o_output_last  out  1  high on row N_OUT-1 beat
i_output_ready  in  1  output ready
i_cfg_valid  in  1  table write request
i_cfg_row  in  clog2(N_OUT)  target row
i_cfg_slot  in  clog2(MAX_W)  target slot
i_cfg_col  in  clog2(N_IN)  entry column
i_cfg_shift  in  clog2(Z)  entry rotate-left amount
i_cfg_enable  in  1  1 = write valid entry, 0 = clear slot
o_cfg_ready  out  1  write accepted this cycle when valid
o_cfg_error  out  1  one-cycle pulse on rejected write

Behaviour:
- Single clock; reset is synchronous and active-high. All state clears on i_reset.
- Reset values: o_input_ready 0, o_output_valid 0, o_output_data 0, o_output_last 0, o_cfg_error 0, o_cfg_ready 0; all table slots invalid; both banks empty; column count 0. Reset mid-frame discards partial and buffered frames.
- Rotation: rotl(d,s) = {d[Z-1-s:0], d[Z-1:Z-s]}; s=0 is identity.
- Fill: on an accepted beat at column c, for every row r, acc[r] <= (c==0 ? 0 : acc[r]) XOR (XOR over valid slots with col==c of rotl(data, shift)). Duplicate matches XOR together, so identical entries cancel. Rows with no entries read 0.
- Column count wraps N_IN-1 -> 0. On the wrap, the fill bank is marked full and fill switches to the other bank.
- Fill FSM states:
  - FILL: o_input_ready=1 unless a cfg write is taken this cycle.
  - WAIT: the target bank is still full; o_input_ready=0. Moves to FILL the cycle after that bank is freed.
- Readout FSM states:
  - IDLE: o_output_valid=0. Moves to READ when the read bank is full.
  - READ: presents acc[row]. The row advances on valid&ready. After row N_OUT-1 is accepted, the bank is freed and the read bank toggles. The FSM goes READ if the other bank is full, else IDLE.
- Latency: the last input beat accepted at cycle t gives o_output_valid=1 at t+1.
- Throughput: zero bubbles with the sink always ready.
- If the fill bank goes full and the read bank is freed in the same cycle, both take effect and there is no stall.
- o_output_data is 0 whenever o_output_valid=0.
- Config:
  - o_cfg_ready=1 only when column count is 0 and not in reset. This blocks writes mid-frame.
  - If cfg and input are both valid at column 0, cfg wins and o_input_ready=0 that cycle.
  - A write with shift>=Z or col>=N_IN is rejected: the table is unchanged and o_cfg_error pulses at t+1.
  - A valid write takes effect from the next input beat.

Decomposition:
- Package sparse_qc_pkg holds:
  - entry struct {valid, col, shift}
  - fill/read state enums
  - rotl function
  - width localparam helpers
- Sub-module sparse_qc_entry_table: holds the config registers and write validation, and outputs per-row match-and-rotate XOR for the current column and data.

Test Plan:
- Default params. Load row0 = {(0,42),(5,67),(7,40),(11,25)}, then a frame with cols 0,5,7,11 = 96'h1 and others 0 -> row0 has bits {25,40,42,67} set, rows 1-3 = 0, o_output_last on 4th beat.
- Same table, 3 back-to-back frames, sink always ready -> o_input_ready never drops, 12 output beats, output of frame k starts one cycle after its col 143.
- i_output_ready=0 -> two frames fill, o_input_ready=0 at col 0 of frame 3 (WAIT). Raise ready -> input resumes the cycle after row 3 of frame 1 is accepted.
- cfg shift=96 -> o_cfg_error pulse, table unchanged. cfg at col 10 mid-frame -> o_cfg_ready=0 and write held until col 0.
- Two slots (3,5) in row1, col 3 = 96'hFF -> row1 = 0. Clear one slot (enable=0) -> row1 = rotl(8'hFF,5).
- Assert i_reset at col 70 with one frame buffered -> all outputs 0, no stale output after reset, next frame computes correctly.
